// File: rtl/zip_bus_pkg.sv
// zip_bus_pkg: shared bus widths, timeout terminal count and watchdog states
package zip_bus_pkg;
  localparam int AW_DEF = 30;
  localparam int DW_DEF = 32;
  typedef enum logic {WD_PASS, WD_ABORT} wd_state_t;
  function automatic int unsigned timeout_tc(input int unsigned lg);
    return (32'd1 << lg) - 32'd1;
  endfunction
endpackage

// File: rtl/zip_bus_timer.sv
// zip_bus_timer: clearable up-counter with a terminal-count flag
module zip_bus_timer #(
  parameter int W = 10,
  parameter logic [W-1:0] TC = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    count <= (rst || clr) ? '0 : inc ? count + 1'b1 : count;
  assign tc = count == TC;
endmodule

// File: rtl/zip_bus_watchdog.sv
// zip_bus_watchdog: Wishbone pass-through that aborts silent slave cycles with a bus error
module zip_bus_watchdog
  import zip_bus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LGTIMEOUT = 10,
  parameter int LGDEPTH = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_m_cyc,
  input  logic            i_m_stb,
  input  logic            i_m_we,
  input  logic [AW-1:0]   i_m_addr,
  input  logic [DW-1:0]   i_m_data,
  input  logic [DW/8-1:0] i_m_sel,
  output logic            o_m_stall,
  output logic            o_m_ack,
  output logic            o_m_err,
  output logic [DW-1:0]   o_m_data,
  output logic            o_s_cyc,
  output logic            o_s_stb,
  output logic            o_s_we,
  output logic [AW-1:0]   o_s_addr,
  output logic [DW-1:0]   o_s_data,
  output logic [DW/8-1:0] o_s_sel,
  input  logic            i_s_stall,
  input  logic            i_s_ack,
  input  logic            i_s_err,
  input  logic [DW-1:0]   i_s_data,
  output logic            o_fault,
  output logic [AW-1:0]   o_fault_addr
);
  localparam logic [LGTIMEOUT-1:0] TC = LGTIMEOUT'(timeout_tc(LGTIMEOUT));
  wd_state_t state, state_nx;
  logic [LGDEPTH-1:0] outstanding;
  logic [AW-1:0] last_addr;
  logic seen, err_q, abort, full, busy, accept, fwd_ack, tclr, tc, timeout;
  assign abort = state == WD_ABORT;
  assign full = &outstanding;
  assign busy = outstanding != '0;
  assign o_s_cyc = i_m_cyc && !abort;
  assign o_s_stb = i_m_stb && !abort && !full;
  assign o_s_we = i_m_we;
  assign o_s_addr = i_m_addr;
  assign o_s_data = i_m_data;
  assign o_s_sel = i_m_sel;
  assign o_m_data = i_s_data;
  assign o_m_stall = i_s_stall || abort || full;
  assign accept = o_s_stb && !i_s_stall;
  assign fwd_ack = i_s_ack && o_s_cyc && busy;
  assign o_m_ack = fwd_ack;
  assign o_m_err = (i_s_err && o_s_cyc) || err_q;
  // any bus progress on the terminal-count cycle suppresses the timeout
  assign tclr = !i_m_cyc || accept || fwd_ack || i_s_err || abort;
  assign timeout = tc && !tclr;
  zip_bus_timer #(.W(LGTIMEOUT), .TC(TC)) u_timer (
    .clk(i_clk),
    .rst(i_reset),
    .clr(tclr || timeout),
    .inc(i_m_cyc && (busy || i_m_stb)),
    .tc(tc)
  );
  always_ff @(posedge i_clk)
    state <= i_reset ? WD_PASS : state_nx;
  always_comb
    state_nx = timeout ? WD_ABORT : (abort && !i_m_cyc) ? WD_PASS : state;
  always_ff @(posedge i_clk)
    if (i_reset) begin
      outstanding <= '0;
      err_q <= 1'b0;
      o_fault <= 1'b0;
      o_fault_addr <= '0;
      last_addr <= '0;
      seen <= 1'b0;
    end else begin
      outstanding <= (!i_m_cyc || i_s_err || timeout) ? '0
                   : outstanding + LGDEPTH'(accept) - LGDEPTH'(fwd_ack);
      err_q <= timeout;
      o_fault <= timeout;
      seen <= i_m_cyc && (accept || seen);
      if (accept) last_addr <= i_m_addr;
      if (timeout) o_fault_addr <= seen ? last_addr : i_m_addr;
    end
endmodule
